// File: rtl/gcd_unit.sv
// gcd_unit: iterative GCD coprocessor with a start/ready handshake.
//
// Default build uses repeated subtract-and-swap. Defining the macro GCD_STEIN_EN
// swaps in the binary (Stein) algorithm: shifts, compares and one subtractor.
// Both modes give the same results, but they report different cycle counts.
//
// Parameters
//   WIDTH  operand/result width in bits (>= 2)
//   CNT_W  width of the iteration counter; the counter saturates at all-ones
//
// Ports
//   clk     rising-edge clock
//   nrst    asynchronous active-low reset
//   start   request, sampled only while ready=1
//   ina     operand A, captured on an accepted start
//   inb     operand B, captured on an accepted start
//   ready   1 = idle, can accept start
//   done    one-cycle pulse, out/cycles valid
//   out     GCD result, held until the next done
//   cycles  busy cycles used by the last operation, held with out
module gcd_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = WIDTH + 2
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [CNT_W-1:0] cycles
);

`ifdef GCD_STEIN_EN
  typedef enum logic [1:0] {StIdle, StShift, StRun, StFix} state_e;
  localparam state_e StFirst = StShift;
  localparam int unsigned KW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  logic [KW-1:0] k_q, k_d;
`else
  typedef enum logic {StIdle, StRun} state_e;
  localparam state_e StFirst = StRun;
`endif

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CNT_W-1:0] count_q, count_d, count_inc;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic             done_q, done_d;
  logic             any_zero;

  // Saturating increment: the counter sticks at all-ones on very long runs.
  assign count_inc = (&count_q) ? count_q : count_q + CntOne;
  assign any_zero  = (a_q == '0) || (b_q == '0);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    out_d    = out_q;
    count_d  = count_q;
    cycles_d = cycles_q;
    done_d   = 1'b0;
`ifdef GCD_STEIN_EN
    k_d      = k_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = ina;
          b_d     = inb;
          count_d = '0;
          state_d = StFirst;
`ifdef GCD_STEIN_EN
          k_d     = '0;
`endif
        end
      end
`ifdef GCD_STEIN_EN
      StShift: begin
        count_d = count_inc;
        if (any_zero) begin
          out_d    = a_q | b_q;
          cycles_d = count_inc;
          done_d   = 1'b1;
          state_d  = StIdle;
        end else if (!a_q[0] && !b_q[0]) begin
          // Common factor of two: remember it in k, restore it in StFix.
          a_d = a_q >> 1;
          b_d = b_q >> 1;
          k_d = k_q + KW'(1);
        end else begin
          state_d = StRun;
        end
      end
      StRun: begin
        count_d = count_inc;
        if (a_q == b_q) begin
          state_d = StFix;
        end else if (!a_q[0]) begin
          a_d = a_q >> 1;
        end else if (!b_q[0]) begin
          b_d = b_q >> 1;
        end else if (a_q > b_q) begin
          a_d = a_q - b_q;
        end else begin
          b_d = b_q - a_q;
        end
      end
      StFix: begin
        out_d    = a_q << k_q;
        cycles_d = count_inc;
        done_d   = 1'b1;
        state_d  = StIdle;
      end
`else
      StRun: begin
        count_d = count_inc;
        if (any_zero) begin
          out_d    = a_q | b_q;
          cycles_d = count_inc;
          done_d   = 1'b1;
          state_d  = StIdle;
        end else if (a_q == b_q) begin
          out_d    = a_q;
          cycles_d = count_inc;
          done_d   = 1'b1;
          state_d  = StIdle;
        end else if (a_q < b_q) begin
          a_d = b_q;
          b_d = a_q;
        end else begin
          a_d = a_q - b_q;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      out_q    <= '0;
      count_q  <= '0;
      cycles_q <= '0;
      done_q   <= 1'b0;
`ifdef GCD_STEIN_EN
      k_q      <= '0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      out_q    <= out_d;
      count_q  <= count_d;
      cycles_q <= cycles_d;
      done_q   <= done_d;
`ifdef GCD_STEIN_EN
      k_q      <= k_d;
`endif
    end
  end

  assign ready  = (state_q == StIdle);
  assign done   = done_q;
  assign out    = out_q;
  assign cycles = cycles_q;

endmodule

// File: tb/tb_gcd_unit.sv
module tb_gcd_unit;

  logic clk = 1'b0;
  logic nrst = 1'b0;

  logic        start8 = 1'b0, ready8, done8;
  logic [7:0]  ina8 = '0, inb8 = '0, out8;
  logic [9:0]  cycles8;

  logic        start16 = 1'b0, ready16, done16;
  logic [15:0] ina16 = '0, inb16 = '0, out16;
  logic [7:0]  cycles16;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int out;
    int cyc;  // exact expected cycles, or -1 to check against bnd only
    int lat;  // exact done latency in cycles, or -1 if not predicted
    int bnd;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];

  gcd_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .nrst(nrst), .start(start8), .ina(ina8), .inb(inb8),
    .ready(ready8), .done(done8), .out(out8), .cycles(cycles8)
  );

  gcd_unit #(.WIDTH(16), .CNT_W(8)) dut16 (
    .clk(clk), .nrst(nrst), .start(start16), .ina(ina16), .inb(inb16),
    .ready(ready16), .done(done16), .out(out16), .cycles(cycles16)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int ref_gcd(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Number of subtract-and-swap steps, counting the finishing step.
  function automatic int sub_steps(input int a, input int b);
    int n = 0;
    int t;
    forever begin
      n++;
      if (a == 0 || b == 0 || a == b) break;
      if (a < b) begin
        t = a; a = b; b = t;
      end else begin
        a = a - b;
      end
    end
    return n;
  endfunction

  function automatic exp_t make_exp(input int a, input int b, input int w, input int cnt_w);
    exp_t e;
    int n, mx;
    e.out = ref_gcd(a, b);
    e.bnd = 4 * w + 2;
`ifdef GCD_STEIN_EN
    e.cyc = -1;
    e.lat = -1;
`else
    n = sub_steps(a, b);
    mx = (1 << cnt_w) - 1;
    e.cyc = (n > mx) ? mx : n;
    e.lat = n;
    e.bnd = n;
`endif
    return e;
  endfunction

  // Drive one start at a negedge; returns one cycle later with start dropped.
  task automatic start_op(input bit w16, input int a, input int b);
    if (w16) begin
      check("rdy16_accept", ready16, 1);
      ina16 = a[15:0]; inb16 = b[15:0]; start16 = 1'b1;
      q16.push_back(make_exp(a, b, 16, 8));
      @(negedge clk);
      start16 = 1'b0;
      ina16 = 16'($urandom); inb16 = 16'($urandom);
      check("busy16", ready16, 0);
    end else begin
      check("rdy8_accept", ready8, 1);
      ina8 = a[7:0]; inb8 = b[7:0]; start8 = 1'b1;
      q8.push_back(make_exp(a, b, 8, 10));
      @(negedge clk);
      start8 = 1'b0;
      ina8 = 8'($urandom); inb8 = 8'($urandom);
      check("busy8", ready8, 0);
    end
  endtask

  // Waits (bounded) for done and scores it; returns in the done cycle.
  task automatic wait_done(input bit w16, input string tag, input bit chk_lat);
    int w = 0;
    int limit = 400;
    int sz;
    exp_t e;
    sz = w16 ? q16.size() : q8.size();
    if (sz > 0) begin
      e = w16 ? q16[0] : q8[0];
      limit = (e.lat >= 0) ? e.lat + 5 : e.bnd + 10;
    end
    while (!(w16 ? done16 : done8) && w < limit) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_done"}, w16 ? done16 : done8, 1);
    check({tag, "_sb"}, (sz > 0), 1);
    if ((w16 ? done16 : done8) && sz > 0) begin
      e = w16 ? q16.pop_front() : q8.pop_front();
      check({tag, "_out"}, w16 ? 32'(out16) : 32'(out8), e.out);
      check({tag, "_rdy"}, w16 ? ready16 : ready8, 1);
      if (e.cyc >= 0) check({tag, "_cyc"}, w16 ? 32'(cycles16) : 32'(cycles8), e.cyc);
      else check({tag, "_cycbnd"}, ((w16 ? 32'(cycles16) : 32'(cycles8)) <= e.bnd), 1);
      if (chk_lat && e.lat >= 0) check({tag, "_lat"}, w, e.lat);
    end
  endtask

  task automatic end_pulse(input bit w16, input string tag);
    @(negedge clk);
    check({tag, "_pulse"}, w16 ? done16 : done8, 0);
  endtask

  initial begin
    int seen;
    int a, b;
    int n_rand;

    // Reset state
    #1;
    check("rst_ready", ready8, 1);
    check("rst_done", done8, 0);
    check("rst_out", out8, 0);
    check("rst_cycles", cycles8, 0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

    // 12,8 -> 4 in four steps
    start_op(0, 12, 8);
    wait_done(0, "g12_8", 1);
    end_pulse(0, "g12_8");
    check("g12_8_hold", out8, 4);

    // Reset in the middle of a long run
    start_op(0, 255, 1);
    repeat (4) @(negedge clk);
    nrst = 1'b0;
    #1;
    check("mid_rst_ready", ready8, 1);
    check("mid_rst_done", done8, 0);
    check("mid_rst_out", out8, 0);
    check("mid_rst_cycles", cycles8, 0);
    void'(q8.pop_back());
    @(negedge clk);
    nrst = 1'b1;
    seen = 0;
    repeat (300) begin
      @(negedge clk);
      if (done8) seen++;
    end
    check("mid_rst_no_done", seen, 0);

    // Zero and equal operands
    start_op(0, 0, 9);
    wait_done(0, "g0_9", 1);
    end_pulse(0, "g0_9");
    start_op(0, 0, 0);
    wait_done(0, "g0_0", 1);
    end_pulse(0, "g0_0");
    start_op(0, 7, 7);
    wait_done(0, "g7_7", 1);
    end_pulse(0, "g7_7");

    // Starts while busy are ignored; a start in the done cycle is taken
    start_op(0, 36, 24);
    ina8 = 8'd99; inb8 = 8'd33; start8 = 1'b1;
    check("busy_ign1", ready8, 0);
    @(negedge clk);
    ina8 = 8'd5; inb8 = 8'd10;
    check("busy_ign2", ready8, 0);
    @(negedge clk);
    start8 = 1'b0;
    wait_done(0, "g36_24", 0);
    start_op(0, 21, 14);
    check("g36_24_pulse", done8, 0);
    check("g36_24_hold", out8, 12);
    wait_done(0, "g21_14", 1);
    end_pulse(0, "g21_14");

    start_op(0, 48, 18);
    wait_done(0, "g48_18", 1);
    end_pulse(0, "g48_18");

    // Random pairs against the reference model
`ifdef GCD_STEIN_EN
    n_rand = 500;
`else
    n_rand = 150;
`endif
    for (int i = 0; i < n_rand; i++) begin
      a = (i % 37 == 0) ? 0 : int'($urandom_range(0, 255));
      b = (i % 41 == 5) ? 0 : int'($urandom_range(0, 255));
      start_op(0, a, b);
      wait_done(0, "rand", 1);
    end
    end_pulse(0, "rand");

    // 16-bit instance: long run with a saturating 8-bit counter
    start_op(1, 1071, 462);
    wait_done(1, "w16_1071", 1);
    end_pulse(1, "w16_1071");
    start_op(1, 65535, 1);
    wait_done(1, "w16_65535", 1);
    end_pulse(1, "w16_65535");
    check("w16_65535_hold", out16, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
